edge_pulse_decoder: RTL
=======================

// Module: edge_pulse_decoder
// PURPOSE
//  Receive-side counterpart of the edge-detector FSM: takes the one-cycle edge-pulse
//  stream and rebuilds the original level waveform. Measures how many cycles each level
//  was held, rejects edge pulses that arrive closer than MIN_WIDTH cycles, and counts
//  accepted edges. Sits downstream of an edge-pulse link in the lab datapath.
// PARAMETERS
//  INIT_LEVEL  1'b0  level_out value after reset / clear
//  MIN_WIDTH   2     min cycles between accepted edges; legal 1..2**CNT_W-1 (1 = no rejection)
//  CNT_W       8     width of width counter / width_out
//  ECNT_W      8     width of accepted-edge counter
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       async reset, active low
//  edge_pulse  in   1       edge event, sampled each clk; one cycle = one edge
//  clear       in   1       sync soft reset (same effect as rst_n, but registered)
//  level_out   out  1       rebuilt level
//  width_out   out  CNT_W   cycles the previous level was held (valid with width_valid)
//  width_valid out  1       1-cycle strobe: width_out/width_ovf updated
//  width_ovf   out  1       width counter saturated before this edge (valid with width_valid)
//  glitch      out  1       1-cycle strobe: edge_pulse rejected (too soon)
//  edge_count  out  ECNT_W  accepted edges since reset/clear, wraps modulo 2**ECNT_W
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, level_out=INIT_LEVEL, cnt=0, width_out=0,
//   width_valid=0, width_ovf=0, glitch=0, edge_count=0. All outputs registered.
//  States: IDLE (no edge since reset/clear), HOLD (cnt<MIN_WIDTH), STABLE (cnt>=MIN_WIDTH).
//  cnt: internal CNT_W counter; set to 1 on accepted edge, else +1 each cycle in
//   HOLD/STABLE, saturating at 2**CNT_W-1. IDLE: cnt holds 0.
//  Accepted edge = edge_pulse=1 in IDLE or STABLE. At that clock edge:
//   level_out toggles (1-cycle latency from edge_pulse sample); cnt<=1; edge_count+1;
//   next state HOLD if MIN_WIDTH>1, else STABLE.
//   From STABLE only: width_out<=cnt, width_ovf<=(cnt==2**CNT_W-1), width_valid<=1.
//   From IDLE: width_valid stays 0 (no previous reference).
//  Rejected edge = edge_pulse=1 in HOLD: level_out, edge_count unchanged;
//   glitch<=1 for one cycle; cnt keeps counting (window not restarted).
//  HOLD->STABLE when next cnt value reaches MIN_WIDTH; STABLE holds until accepted edge.
//  width_valid, glitch: high exactly one cycle per event, else 0. width_out holds last value.
//  Back-to-back accepted edges (MIN_WIDTH=1, edge_pulse high N cycles): level toggles
//   every cycle, width_out=1 each time after the first.
//  clear=1: next clock same values as reset; clear wins over simultaneous edge_pulse.
//  rst_n asserted mid-measurement: immediate return to reset values, no width_valid.
//  edge_count wraps 2**ECNT_W-1 -> 0 without flag.
// TESTING
//  1 Reset, INIT_LEVEL=0, MIN_WIDTH=2: edge_pulse at cycles 5,15 -> level_out 1 at 6,
//    0 at 16; width_valid only at 16 with width_out=10; edge_count=2.
//  2 MIN_WIDTH=3: accepted edge at cycle 10, edge at 11 and 12 -> glitch at 12 and 13,
//    level_out unchanged; edge at 13 accepted, width_out=3.
//  3 MIN_WIDTH=1: edge_pulse high cycles 20..23 -> level_out toggles 21..24, width_valid
//    at 22,23,24 with width_out=1, glitch never.
//  4 CNT_W=4: accepted edges 40 cycles apart -> width_out=15, width_ovf=1; next gap 5 ->
//    width_out=5, width_ovf=0.
//  5 clear and edge_pulse together in STABLE -> level_out=INIT_LEVEL, edge_count=0,
//    no width_valid; next edge from IDLE gives no width_valid.
//  6 rst_n low mid-HOLD (async, between clocks) -> all outputs at reset values immediately;
//    256 accepted edges with ECNT_W=8 -> edge_count wraps to 0.

Source files
------------

// File: rtl/edge_pulse_decoder.sv
// -----------------------------------------------------------------------------
// edge_pulse_decoder
//
// Rebuilds a level waveform from a stream of one-cycle edge pulses. Each
// accepted pulse toggles the rebuilt level. The module also reports how long
// the previous level was held, and it rejects pulses that arrive sooner than
// MIN_WIDTH cycles after the last accepted edge. Accepted edges are counted.
//
// Parameters
//   INIT_LEVEL  level_out value after reset / clear
//   MIN_WIDTH   minimum cycles between accepted edges (1..2**CNT_W-1)
//   CNT_W       width of the hold-time counter and width_out
//   ECNT_W      width of the accepted-edge counter
//
// Ports
//   clk          in   1       clock, rising edge
//   rst_n        in   1       asynchronous reset, active low
//   edge_pulse   in   1       edge event, one cycle high per edge
//   clear        in   1       synchronous soft reset (same values as rst_n)
//   level_out    out  1       rebuilt level
//   width_out    out  CNT_W   cycles the previous level was held
//   width_valid  out  1       one-cycle strobe: width_out/width_ovf updated
//   width_ovf    out  1       hold counter was saturated at the measured edge
//   glitch       out  1       one-cycle strobe: edge_pulse rejected (too soon)
//   edge_count   out  ECNT_W  accepted edges since reset/clear (wraps)
// -----------------------------------------------------------------------------
module edge_pulse_decoder #(
    parameter logic INIT_LEVEL = 1'b0,
    parameter int   MIN_WIDTH  = 2,
    parameter int   CNT_W      = 8,
    parameter int   ECNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              edge_pulse,
    input  logic              clear,
    output logic              level_out,
    output logic [CNT_W-1:0]  width_out,
    output logic              width_valid,
    output logic              width_ovf,
    output logic              glitch,
    output logic [ECNT_W-1:0] edge_count
);

    // IDLE: no edge seen since reset/clear, so there is no width reference.
    // HOLD: inside the rejection window after an accepted edge.
    // STABLE: window elapsed, next pulse is accepted and measured.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HOLD   = 2'b01,
        ST_STABLE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  MIN_W     = CNT_W'(MIN_WIDTH);
    localparam logic [ECNT_W-1:0] ECNT_ZERO = {ECNT_W{1'b0}};
    localparam logic [ECNT_W-1:0] ECNT_ONE  = {{(ECNT_W-1){1'b0}}, 1'b1};

    // With MIN_WIDTH of 1 the window is already satisfied once cnt is 1,
    // so an accepted edge goes straight back to STABLE.
    localparam state_t ACCEPT_STATE = (MIN_WIDTH > 32'sd1) ? ST_HOLD : ST_STABLE;

    // Saturating increment: the counter sticks at all-ones so an overlong
    // level reads as "at least CNT_MAX" instead of wrapping to a short value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                level_r;
    logic [CNT_W-1:0]    width_r;
    logic                width_valid_r;
    logic                width_ovf_r;
    logic                glitch_r;
    logic [ECNT_W-1:0]   edge_count_r;
    logic [CNT_W-1:0]    cnt_inc_s;

    // Next hold-count value when no edge is accepted this cycle.
    always_comb begin
        cnt_inc_s = sat_inc(cnt_r);
    end

    // Decoder state machine with all outputs held in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            level_r       <= INIT_LEVEL;
            width_r       <= CNT_ZERO;
            width_valid_r <= 1'b0;
            width_ovf_r   <= 1'b0;
            glitch_r      <= 1'b0;
            edge_count_r  <= ECNT_ZERO;
        end else if (clear) begin
            // Soft reset takes priority over a coincident edge pulse.
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            level_r       <= INIT_LEVEL;
            width_r       <= CNT_ZERO;
            width_valid_r <= 1'b0;
            width_ovf_r   <= 1'b0;
            glitch_r      <= 1'b0;
            edge_count_r  <= ECNT_ZERO;
        end else begin
            // Strobes are high for a single cycle only.
            width_valid_r <= 1'b0;
            glitch_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (edge_pulse) begin
                        // First edge: nothing to measure against yet.
                        level_r      <= ~level_r;
                        cnt_r        <= CNT_ONE;
                        edge_count_r <= edge_count_r + ECNT_ONE;
                        state_r      <= ACCEPT_STATE;
                    end else begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    // A pulse here is rejected; the window keeps running
                    // from the last accepted edge rather than restarting.
                    if (edge_pulse) begin
                        glitch_r <= 1'b1;
                    end else begin
                        glitch_r <= 1'b0;
                    end
                    cnt_r <= cnt_inc_s;
                    if (cnt_inc_s >= MIN_W) begin
                        state_r <= ST_STABLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_STABLE: begin
                    if (edge_pulse) begin
                        // cnt_r is the number of cycles the old level lasted.
                        width_r       <= cnt_r;
                        width_ovf_r   <= (cnt_r == CNT_MAX);
                        width_valid_r <= 1'b1;
                        level_r       <= ~level_r;
                        cnt_r         <= CNT_ONE;
                        edge_count_r  <= edge_count_r + ECNT_ONE;
                        state_r       <= ACCEPT_STATE;
                    end else begin
                        cnt_r   <= cnt_inc_s;
                        state_r <= ST_STABLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign level_out   = level_r;
    assign width_out   = width_r;
    assign width_valid = width_valid_r;
    assign width_ovf   = width_ovf_r;
    assign glitch      = glitch_r;
    assign edge_count  = edge_count_r;

endmodule
